// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory handshake, hazard/redirect controls and
// the instruction presented to the IF/ID register.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        input  stall, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight and buffers the returned instruction for the IF/ID register.
module fetch_stage #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fe
);
    // state | meaning
    // START | first cycle out of reset, no request yet
    // FETCH | request on the bus this cycle
    // WAIT  | request outstanding, response wanted
    // HOLD  | instruction buffered and presented to IF/ID
    // DROP  | request outstanding, response will be discarded
    typedef enum logic [2:0] {
        START = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] w_pc_nxt;
    logic [63:0] r_buf_pc;
    logic [63:0] w_buf_pc_nxt;
    logic [31:0] r_buf_instr;
    logic [31:0] w_buf_instr_nxt;
    logic [63:0] w_redirect_pc;

    // Branch targets are word aligned; low bits from the redirect source are dropped.
    assign w_redirect_pc = {fe.redirect_pc[63:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_buf_pc    <= 64'd0;
            r_buf_instr <= 32'd0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_buf_instr <= w_buf_instr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_buf_pc_nxt    = r_buf_pc;
        w_buf_instr_nxt = r_buf_instr;
        case (r_state)
            START: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (fe.redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = DROP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (fe.redirect) begin
                    // A simultaneous ack retires the stale request, so refetch at once.
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = fe.imem_ack ? FETCH : DROP;
                end else if (fe.imem_ack) begin
                    w_buf_pc_nxt    = r_pc;
                    w_buf_instr_nxt = fe.imem_rdata;
                    w_pc_nxt        = r_pc + 64'd4;
                    w_state_nxt     = HOLD;
                end
            end
            DROP: begin
                if (fe.redirect) begin
                    w_pc_nxt = w_redirect_pc;
                end
                if (fe.imem_ack) begin
                    w_state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (fe.redirect) begin
                    w_pc_nxt    = w_redirect_pc;
                    w_state_nxt = FETCH;
                end else if (!fe.stall) begin
                    w_state_nxt = FETCH;
                end
            end
            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    assign fe.imem_req  = (r_state == FETCH);
    assign fe.imem_addr = r_pc;
    assign fe.if_valid  = (r_state == HOLD);
    assign fe.if_pc     = r_buf_pc;
    assign fe.if_instr  = (r_state == HOLD) ? r_buf_instr : 32'd0;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic, all checked
// every cycle against a transaction-level model of the fetch pipeline.
module tb_fetch_stage;
    localparam logic [63:0] RPC_A = 64'h0000_0000_0000_1000;
    localparam logic [63:0] RPC_W = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_stage_if bus();
    fetch_stage_if bus_w();

    fetch_stage #(.RESET_PC(RPC_A)) dut   (.clk(clk), .rst(rst), .fe(bus));
    fetch_stage #(.RESET_PC(RPC_W)) dut_w (.clk(clk), .rst(rst), .fe(bus_w));

    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // model: what the fetch pipeline should be doing right now
    bit          m_start, m_due, m_busy, m_drop, m_have;
    logic [63:0] m_pc, m_bpc;
    logic [31:0] m_binstr;
    logic [63:0] consumed_pc[$];

    // memory responder
    bit          mem_pend;
    int          mem_wait;
    int          mem_lat = 1;
    logic [63:0] mem_addr;
    bit          mem_ovr_en;
    logic [31:0] mem_ovr_val;
    bit          force_ack;
    logic [63:0] req_log[$];

    // second instance (wrap-around reset PC)
    bit          w_ack;
    logic [63:0] w_addr;
    logic [63:0] w_req_log[$];

    logic        stall_i, redir_i;
    logic [63:0] rpc_i;
    logic [63:0] hold_pc;

    function automatic logic [31:0] hash(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_start  = 1'b1;
        m_due    = 1'b0;
        m_busy   = 1'b0;
        m_drop   = 1'b0;
        m_have   = 1'b0;
        m_pc     = RPC_A;
        m_bpc    = 64'd0;
        m_binstr = 32'd0;
        mem_pend = 1'b0;
    endtask

    task automatic model_check();
        check("imem_req",  {63'd0, bus.imem_req}, {63'd0, m_due});
        check("imem_addr", bus.imem_addr, m_pc);
        check("if_valid",  {63'd0, bus.if_valid}, {63'd0, m_have});
        check("if_pc",     bus.if_pc, m_bpc);
        check("if_instr",  {32'd0, bus.if_instr}, {32'd0, (m_have ? m_binstr : 32'd0)});
    endtask

    task automatic model_update(input bit a, input logic [31:0] d);
        logic [63:0] rp;
        rp = {rpc_i[63:2], 2'b00};
        if (m_start) begin
            m_start = 1'b0;
            m_due   = 1'b1;
        end else if (m_due) begin
            m_due = 1'b0;
            if (redir_i) begin
                m_drop = 1'b1;
                m_pc   = rp;
            end else begin
                m_busy = 1'b1;
            end
        end else if (m_busy) begin
            if (redir_i) begin
                m_busy = 1'b0;
                m_pc   = rp;
                if (a) m_due = 1'b1;
                else   m_drop = 1'b1;
            end else if (a) begin
                m_busy   = 1'b0;
                m_have   = 1'b1;
                m_bpc    = m_pc;
                m_binstr = d;
                m_pc     = m_pc + 64'd4;
            end
        end else if (m_drop) begin
            if (redir_i) m_pc = rp;
            if (a) begin
                m_drop = 1'b0;
                m_due  = 1'b1;
            end
        end else if (m_have) begin
            if (redir_i) begin
                m_have = 1'b0;
                m_pc   = rp;
                m_due  = 1'b1;
            end else if (!stall_i) begin
                m_have = 1'b0;
                m_due  = 1'b1;
                consumed_pc.push_back(m_bpc);
            end
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model at the rising edge.
    task automatic cycle();
        bit          a;
        logic [31:0] d;
        a = 1'b0;
        d = $urandom;
        if (force_ack) begin
            a = 1'b1;
            d = 32'h0BAD_0BAD;
        end
        if (mem_pend) begin
            mem_wait--;
            if (mem_wait == 0) begin
                a        = 1'b1;
                mem_pend = 1'b0;
                d        = mem_ovr_en ? mem_ovr_val : hash(mem_addr);
                mem_ovr_en = 1'b0;
            end
        end
        bus.stall       = stall_i;
        bus.redirect    = redir_i;
        bus.redirect_pc = rpc_i;
        bus.imem_ack    = a;
        bus.imem_rdata  = d;
        if (bus.imem_req) begin
            mem_pend = 1'b1;
            mem_wait = mem_lat;
            mem_addr = bus.imem_addr;
            req_log.push_back(bus.imem_addr);
        end
        bus_w.imem_ack   = w_ack;
        bus_w.imem_rdata = hash(w_addr);
        w_ack  = bus_w.imem_req;
        w_addr = bus_w.imem_addr;
        if (bus_w.imem_req && w_req_log.size() < 4) w_req_log.push_back(bus_w.imem_addr);
        model_check();
        @(posedge clk);
        model_update(a, d);
        @(negedge clk);
        force_ack = 1'b0;
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return m_have;
            1:       return m_busy;
            2:       return req_log.size() > 0;
            3:       return consumed_pc.size() >= 3;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_until(input int what, input string tag);
        int n;
        n = 0;
        while (!cond(what) && n < 40) begin
            cycle();
            n++;
        end
        check(tag, {63'd0, cond(what)}, 64'd1);
    endtask

    initial begin
        bus.stall = 1'b0;   bus.redirect = 1'b0;   bus.redirect_pc = 64'd0;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0;
        bus_w.stall = 1'b0; bus_w.redirect = 1'b0; bus_w.redirect_pc = 64'd0;
        bus_w.imem_ack = 1'b0; bus_w.imem_rdata = 32'd0;
        stall_i = 1'b0; redir_i = 1'b0; rpc_i = 64'd0;
        w_ack = 1'b0; w_addr = 64'd0;
        mem_ovr_en = 1'b0; force_ack = 1'b0;
        model_reset();

        // reset values
        repeat (2) @(negedge clk);
        model_check();
        check("rst_addr_w", bus_w.imem_addr, RPC_W);
        check("rst_req_w", {63'd0, bus_w.imem_req}, 64'd0);
        rst = 1'b0;

        // straight-line fetch, latency 1, no stall
        req_log.delete();
        consumed_pc.delete();
        run_until(3, "tmo_seq");
        check("seq_req0", req_log[0], 64'h1000);
        check("seq_req1", req_log[1], 64'h1004);
        check("seq_req2", req_log[2], 64'h1008);
        check("seq_con0", consumed_pc[0], 64'h1000);
        check("seq_con1", consumed_pc[1], 64'h1004);
        check("seq_con2", consumed_pc[2], 64'h1008);

        // stall for 4 cycles while holding a known instruction
        stall_i = 1'b1;
        mem_ovr_en = 1'b1; mem_ovr_val = 32'h00A0_0093;
        run_until(0, "tmo_stall_hold");
        hold_pc = bus.if_pc;
        for (int i = 0; i < 4; i++) begin
            check("stall_valid", {63'd0, bus.if_valid}, 64'd1);
            check("stall_pc", bus.if_pc, 64'h100C);
            check("stall_instr", {32'd0, bus.if_instr}, 64'h00A0_0093);
            check("stall_noreq", {63'd0, bus.imem_req}, 64'd0);
            cycle();
        end
        stall_i = 1'b0;
        cycle();
        check("stall_next_req", {63'd0, bus.imem_req}, 64'd1);
        check("stall_next_addr", bus.imem_addr, hold_pc + 64'd4);

        // redirect during WAIT, stale response arrives 3 cycles later
        mem_lat = 4;
        mem_ovr_en = 1'b1; mem_ovr_val = 32'hDEAD_BEEF;
        run_until(1, "tmo_wait_a");
        req_log.delete();
        redir_i = 1'b1; rpc_i = 64'h2002;
        cycle();
        redir_i = 1'b0; mem_lat = 1;
        run_until(2, "tmo_redir_req");
        check("redir_req_addr", req_log[0], 64'h2000);
        run_until(0, "tmo_redir_hold");
        check("redir_if_pc", bus.if_pc, 64'h2000);
        check("redir_if_instr", {32'd0, bus.if_instr}, {32'd0, hash(64'h2000)});

        // redirect coinciding with ack in WAIT
        mem_lat = 2;
        run_until(1, "tmo_wait_b");
        cycle();
        redir_i = 1'b1; rpc_i = 64'h3000;
        cycle();
        redir_i = 1'b0; mem_lat = 1;
        check("sameack_req", {63'd0, bus.imem_req}, 64'd1);
        check("sameack_addr", bus.imem_addr, 64'h3000);
        run_until(0, "tmo_sameack_hold");
        check("sameack_if_pc", bus.if_pc, 64'h3000);

        // redirect while stalled in HOLD
        stall_i = 1'b1;
        run_until(0, "tmo_hold_c");
        redir_i = 1'b1; rpc_i = 64'h4000;
        cycle();
        redir_i = 1'b0; stall_i = 1'b0;
        check("holdredir_valid", {63'd0, bus.if_valid}, 64'd0);
        check("holdredir_req", {63'd0, bus.imem_req}, 64'd1);
        check("holdredir_addr", bus.imem_addr, 64'h4000);

        // PC wrap on the second instance
        check("wrap_req0", w_req_log[0], RPC_W);
        check("wrap_req1", w_req_log[1], 64'd0);

        // asynchronous reset during WAIT; late ack lands in START and FETCH
        mem_lat = 3;
        run_until(1, "tmo_wait_rst");
        #2 rst = 1'b1;
        #1;
        check("arst_req", {63'd0, bus.imem_req}, 64'd0);
        check("arst_addr", bus.imem_addr, RPC_A);
        check("arst_valid", {63'd0, bus.if_valid}, 64'd0);
        check("arst_if_pc", bus.if_pc, 64'd0);
        check("arst_instr", {32'd0, bus.if_instr}, 64'd0);
        check("arst_addr_w", bus_w.imem_addr, RPC_W);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        mem_lat = 1;
        force_ack = 1'b1;
        cycle();
        force_ack = 1'b1;
        cycle();
        run_until(0, "tmo_after_rst");
        check("after_rst_pc", bus.if_pc, RPC_A);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            stall_i = ($urandom_range(0, 9) < 3);
            redir_i = ($urandom_range(0, 11) == 0);
            rpc_i   = {$urandom, $urandom};
            mem_lat = $urandom_range(1, 4);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It sits directly upstream of the IF/ID register. It owns the 64-bit PC, issues one instruction-memory request at a time over a request/acknowledge handshake, and buffers the returned 32-bit instruction with its PC. It presents `if_valid`/`if_pc`/`if_instr` to IF/ID, honours `stall` from the hazard unit, and squashes in-flight fetches on a branch/jump `redirect`.

## Interface
- `RESET_PC`, default 64'h0000_0000_0000_0000: PC fetched first after reset.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `stall` in 1: IF/ID cannot accept this cycle.
- `redirect` in 1: taken branch/jump; flush and refetch from `redirect_pc`.
- `redirect_pc` in 64: new fetch address.
- `imem_req` out 1: one-cycle request pulse.
- `imem_addr` out 64: fetch address; stable from the `imem_req` cycle until `imem_ack`.
- `imem_ack` in 1: one-cycle response strobe.
- `imem_rdata` in 32: instruction, valid with `imem_ack`.
- `if_valid` out 1: `if_pc`/`if_instr` hold a valid instruction.
- `if_pc` out 64: PC of the buffered instruction.
- `if_instr` out 32: buffered instruction; 32'h0 when `if_valid`=0.

## Operation
- State register: START, FETCH, WAIT, HOLD, DROP. Reset state is START.
- Registers: `pc` (64), `buf_pc` (64), `buf_instr` (32).
- `imem_req` = (state==FETCH). `imem_addr` = `pc`. `if_valid` = (state==HOLD). `if_pc` = `buf_pc`. `if_instr` = `buf_instr` when HOLD, else 0.
- START: always goes to FETCH. No request is issued in START.
- FETCH: the request is issued.
  - No redirect: go to WAIT.
  - Redirect: `pc` <= `redirect_pc`, go to DROP. The request is already out, so its response must be discarded.
- WAIT:
  - Ack with no redirect: `buf_pc` <= `pc`, `buf_instr` <= `imem_rdata`, `pc` <= `pc`+4, go to HOLD.
  - Redirect with no ack: `pc` <= `redirect_pc`, go to DROP.
  - Redirect and ack in the same cycle: discard the data, `pc` <= `redirect_pc`, go to FETCH.
  - Neither: stay in WAIT.
- DROP:
  - Ack: discard the data, go to FETCH.
  - Redirect: `pc` <= `redirect_pc`. This applies with or without ack; the state decision above is unchanged.
- HOLD:
  - Redirect has priority: `pc` <= `redirect_pc`, go to FETCH. The buffered instruction is flushed and is never counted as consumed.
  - Otherwise, `stall`=0: the instruction is consumed by IF/ID at this edge; go to FETCH.
  - Otherwise, `stall`=1: stay in HOLD with the buffer unchanged.
- `imem_ack` is ignored in START, FETCH and HOLD.
- Arithmetic and alignment:
  - `pc`+4 is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
  - `redirect_pc[1:0]` is forced to 2'b00 when loaded.
  - `RESET_PC` must be 4-byte aligned.

## Timing
- Reset values:
  - State START, `pc`=`RESET_PC`, `buf_pc`=0, `buf_instr`=0.
  - Outputs: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=0.
- Reset asserted mid-fetch: all state is cleared immediately. A later ack for the abandoned request arrives in START or FETCH and is ignored.
- First `imem_req` appears in the 2nd cycle after `rst` deasserts.
- Memory latency is at least 1 cycle: ack comes no earlier than the cycle after `imem_req`.
- Latency from request to `if_valid`, with ack latency L: `if_valid` rises L+1 cycles after the `imem_req` cycle.
- Peak throughput is one instruction per 3 cycles (FETCH, WAIT+ack, HOLD).
- Only one request is ever outstanding. A new `imem_req` never issues before the previous request's ack.
- `redirect` takes effect at the edge where it is sampled. The next `imem_req` carrying `redirect_pc` comes at most 1 cycle after the discarded ack, or 1 cycle after the redirect when in HOLD or WAIT-with-ack.

## Test plan
- Reset release, `RESET_PC`=0x1000, ack latency 1, `stall`=0 -> `imem_req` with addr 0x1000, 0x1004, 0x1008. `if_valid` pulses carry `if_pc`=0x1000/0x1004/0x1008 and the matching `if_instr`.
- `stall`=1 for 4 cycles while in HOLD with instruction 0x00A00093 -> `if_valid`, `if_pc` and `if_instr` constant for 4 cycles. No `imem_req` during the stall. The next req comes at `pc`+4 after release.
- Redirect to 0x2002 during WAIT, ack 3 cycles later with 0xDEADBEEF -> that data is never presented. Next `imem_req` addr is 0x2000. `if_pc`=0x2000.
- Redirect to 0x3000 in the same cycle as ack in WAIT -> ack data discarded. `imem_req` to 0x3000 on the next cycle.
- Redirect to 0x4000 in HOLD with `stall`=1 -> `if_valid` drops the next cycle. `imem_req` to 0x4000.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC -> second request addr is 0. Also assert `rst` during WAIT -> all outputs return to their reset values immediately, and the late ack is ignored.
